id_stage_reg: RTL and testbench
===============================

ID_STAGE_REG -- requirements
Module: id_stage_reg

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, width of PC and operand value fields.
REQ-002 SHALL provide clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide flush  input  1  branch taken in EXE; squash the instruction being captured.
REQ-005 SHALL provide freeze  input  1  pipeline stall (memory busy or hazard); hold all state.
REQ-006 SHALL provide control inputs MEM_r_en_in, MEM_w_en_in, WB_en_in, s_in, b_in  input  1 each  decoder outputs for the instruction in ID.
REQ-007 SHALL provide exec_cmd_in  input  4  ALU command from the decoder.
REQ-008 SHALL provide pc_in, val_rn_in, val_rm_in  input  DATA_W each  PC+4 and register-file read values.
REQ-009 SHALL provide imm_in  input  1; shift_operand_in  input  12; signed_imm_24_in  input  24  operand-2 and branch-offset fields.
REQ-010 SHALL provide dest_in, src1_in, src2_in  input  4 each  destination and source register numbers.
REQ-011 SHALL provide carry_in  input  1  current C flag from the status register.
REQ-012 SHALL provide one registered output per input of REQ-006..REQ-011, same width, suffix _out in place of _in.
REQ-013 SHALL provide valid_out  output  1  high when the EXE-stage slot holds a real instruction.
REQ-014 SHALL provide squash_count  output  8  saturating count of instructions squashed by flush since reset.

Function
REQ-015 SHALL update state only on rising clk edge, except asynchronous reset.
REQ-016 SHALL give priority rst > freeze > flush > normal load.
REQ-017 With freeze=1 SHALL hold every output, including valid_out and squash_count, regardless of flush.
REQ-018 With freeze=0, flush=1 SHALL load a bubble: MEM_r_en_out, MEM_w_en_out, WB_en_out, s_out, b_out=0; exec_cmd_out=0; valid_out=0; all data/register-number outputs=0.
REQ-019 With freeze=0, flush=1 SHALL increment squash_count by 1, saturating at 255 (no wrap).
REQ-020 With freeze=0, flush=0 SHALL capture every _in into its _out and set valid_out=1.
REQ-021 SHALL have latency exactly one clock from _in to _out; no combinational path from any input to any output.
REQ-022 SHALL register carry_in with the instruction so ADC/SBC in EXE use the C flag sampled at ID.
REQ-023 SHALL never present MEM_r_en_out=1 and MEM_w_en_out=1 together; on such input SHALL load a bubble (no squash_count increment) and treat the cycle as invalid.
REQ-024 A flush held across multiple freeze cycles SHALL take effect once, on the first cycle freeze=0.
REQ-025 SHALL ignore s_in meaning-wise; it is stored unchanged (memory/arith distinction already resolved upstream).

Reset
REQ-026 On rst=1, immediately and independent of clk, SHALL clear all outputs to 0, including valid_out and squash_count.
REQ-027 Reset asserted mid-freeze or mid-flush SHALL win; after rst falls, the first rising edge follows REQ-016 normally.
REQ-028 SHALL not require clk to be running during reset.

Verification
REQ-029 Load: rst then WB_en_in=1, exec_cmd_in=4'b0010, val_rn_in=32'h0000_0005, dest_in=3, one edge -> WB_en_out=1, exec_cmd_out=4'b0010, val_rn_out=5, dest_out=3, valid_out=1.
REQ-030 Freeze: after REQ-029, change all inputs, freeze=1 for 3 edges -> outputs unchanged; freeze=0 one edge -> new values captured.
REQ-031 Flush: valid instruction loaded, then flush=1, MEM_w_en_in=1 one edge -> all controls 0, valid_out=0, squash_count=1.
REQ-032 Freeze+flush: freeze=1, flush=1 for 2 edges -> hold, squash_count unchanged; freeze=0, flush=1 one edge -> bubble, squash_count +1.
REQ-033 Saturation: 300 flush edges -> squash_count=255; illegal MEM_r_en_in=MEM_w_en_in=1 -> bubble, count stays 255.
REQ-034 Async reset: assert rst between edges with valid_out=1 -> all outputs 0 before next edge; carry_in=1 load after release -> carry_out=1.

Source files
------------

// File: rtl/id_stage_reg.sv
// ID/EXE pipeline register: carries decoded control, operands and the C flag
// into EXE, turning flushed or illegal instructions into bubbles.
module id_stage_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic              MEM_r_en_in,
    input  logic              MEM_w_en_in,
    input  logic              WB_en_in,
    input  logic              s_in,
    input  logic              b_in,
    input  logic [3:0]        exec_cmd_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val_rn_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic              imm_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       signed_imm_24_in,
    input  logic [3:0]        dest_in,
    input  logic [3:0]        src1_in,
    input  logic [3:0]        src2_in,
    input  logic              carry_in,
    output logic              MEM_r_en_out,
    output logic              MEM_w_en_out,
    output logic              WB_en_out,
    output logic              s_out,
    output logic              b_out,
    output logic [3:0]        exec_cmd_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] val_rn_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic              imm_out,
    output logic [11:0]       shift_operand_out,
    output logic [23:0]       signed_imm_24_out,
    output logic [3:0]        dest_out,
    output logic [3:0]        src1_out,
    output logic [3:0]        src2_out,
    output logic              carry_out,
    output logic              valid_out,
    output logic [7:0]        squash_count
);

    // A simultaneous memory read and write is a decoder fault: drop it
    // as a bubble, but only a real flush counts as a squash.
    logic illegal_mem;
    logic capture;

    assign illegal_mem = MEM_r_en_in & MEM_w_en_in;
    assign capture     = ~flush & ~illegal_mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            MEM_r_en_out      <= 1'b0;
            MEM_w_en_out      <= 1'b0;
            WB_en_out         <= 1'b0;
            s_out             <= 1'b0;
            b_out             <= 1'b0;
            exec_cmd_out      <= 4'd0;
            pc_out            <= '0;
            val_rn_out        <= '0;
            val_rm_out        <= '0;
            imm_out           <= 1'b0;
            shift_operand_out <= 12'd0;
            signed_imm_24_out <= 24'd0;
            dest_out          <= 4'd0;
            src1_out          <= 4'd0;
            src2_out          <= 4'd0;
            carry_out         <= 1'b0;
            valid_out         <= 1'b0;
            squash_count      <= 8'd0;
        end else if (!freeze) begin
            MEM_r_en_out      <= capture & MEM_r_en_in;
            MEM_w_en_out      <= capture & MEM_w_en_in;
            WB_en_out         <= capture & WB_en_in;
            s_out             <= capture & s_in;
            b_out             <= capture & b_in;
            exec_cmd_out      <= capture ? exec_cmd_in      : 4'd0;
            pc_out            <= capture ? pc_in            : '0;
            val_rn_out        <= capture ? val_rn_in        : '0;
            val_rm_out        <= capture ? val_rm_in        : '0;
            imm_out           <= capture & imm_in;
            shift_operand_out <= capture ? shift_operand_in : 12'd0;
            signed_imm_24_out <= capture ? signed_imm_24_in : 24'd0;
            dest_out          <= capture ? dest_in          : 4'd0;
            src1_out          <= capture ? src1_in          : 4'd0;
            src2_out          <= capture ? src2_in          : 4'd0;
            carry_out         <= capture & carry_in;
            valid_out         <= capture;
            if (flush && squash_count != 8'hFF) begin
                squash_count <= squash_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_reg.sv
// Randomized scoreboard bench for id_stage_reg: a spec-level model pushes the
// expected EXE-slot contents each edge, a negedge monitor pops and compares.
module tb_id_stage_reg;

    localparam int DW = 32;

    typedef struct packed {
        logic          mem_r, mem_w, wb, s, b;
        logic [3:0]    cmd;
        logic [DW-1:0] pc, rn, rm;
        logic          imm;
        logic [11:0]   sh;
        logic [23:0]   simm;
        logic [3:0]    dest, s1, s2;
        logic          carry;
    } in_t;

    typedef struct packed {
        in_t        ins;
        logic       valid;
        logic [7:0] cnt;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic freeze = 1'b0;
    in_t  stim = '0;

    logic          MEM_r_en_out, MEM_w_en_out, WB_en_out, s_out, b_out;
    logic [3:0]    exec_cmd_out;
    logic [DW-1:0] pc_out, val_rn_out, val_rm_out;
    logic          imm_out;
    logic [11:0]   shift_operand_out;
    logic [23:0]   signed_imm_24_out;
    logic [3:0]    dest_out, src1_out, src2_out;
    logic          carry_out, valid_out;
    logic [7:0]    squash_count;

    int errors = 0;
    int checks = 0;
    out_t expQ[$];
    out_t model = '0;

    always #5 clk = ~clk;

    id_stage_reg #(.DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
        .MEM_r_en_in(stim.mem_r), .MEM_w_en_in(stim.mem_w), .WB_en_in(stim.wb),
        .s_in(stim.s), .b_in(stim.b), .exec_cmd_in(stim.cmd),
        .pc_in(stim.pc), .val_rn_in(stim.rn), .val_rm_in(stim.rm),
        .imm_in(stim.imm), .shift_operand_in(stim.sh), .signed_imm_24_in(stim.simm),
        .dest_in(stim.dest), .src1_in(stim.s1), .src2_in(stim.s2), .carry_in(stim.carry),
        .MEM_r_en_out(MEM_r_en_out), .MEM_w_en_out(MEM_w_en_out), .WB_en_out(WB_en_out),
        .s_out(s_out), .b_out(b_out), .exec_cmd_out(exec_cmd_out),
        .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
        .imm_out(imm_out), .shift_operand_out(shift_operand_out),
        .signed_imm_24_out(signed_imm_24_out), .dest_out(dest_out),
        .src1_out(src1_out), .src2_out(src2_out), .carry_out(carry_out),
        .valid_out(valid_out), .squash_count(squash_count)
    );

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input in_t s, input logic fr, input logic fl);
        stim   = s;
        freeze = fr;
        flush  = fl;
        @(posedge clk);
        #1;
    endtask

    function automatic in_t randStim(input bit legal);
        in_t s;
        s.mem_r = 1'($urandom);
        s.mem_w = 1'($urandom);
        if (legal && s.mem_r) s.mem_w = 1'b0;
        s.wb    = 1'($urandom);
        s.s     = 1'($urandom);
        s.b     = 1'($urandom);
        s.cmd   = 4'($urandom);
        s.pc    = DW'($urandom);
        s.rn    = DW'($urandom);
        s.rm    = DW'($urandom);
        s.imm   = 1'($urandom);
        s.sh    = 12'($urandom);
        s.simm  = 24'($urandom);
        s.dest  = 4'($urandom);
        s.s1    = 4'($urandom);
        s.s2    = 4'($urandom);
        s.carry = 1'($urandom);
        return s;
    endfunction

    // Reference behaviour: a stall keeps the slot, a flush or an illegal
    // read+write leaves an empty slot, anything else moves into EXE.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model = '0;
                expQ.delete();
            end else begin
                if (!freeze) begin
                    if (flush) begin
                        model.ins   = '0;
                        model.valid = 1'b0;
                        if (model.cnt < 8'd255) model.cnt = model.cnt + 8'd1;
                    end else if (stim.mem_r && stim.mem_w) begin
                        model.ins   = '0;
                        model.valid = 1'b0;
                    end else begin
                        model.ins   = stim;
                        model.valid = 1'b1;
                    end
                end
                expQ.push_back(model);
            end
        end
    end

    initial begin
        out_t exp, act;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                exp = expQ.pop_front();
                act.ins = {MEM_r_en_out, MEM_w_en_out, WB_en_out, s_out, b_out, exec_cmd_out,
                           pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
                           signed_imm_24_out, dest_out, src1_out, src2_out, carry_out};
                act.valid = valid_out;
                act.cnt   = squash_count;
                checkOutput("sb_fields", 256'(act.ins), 256'(exp.ins));
                checkOutput("sb_valid", 256'(act.valid), 256'(exp.valid));
                checkOutput("sb_count", 256'(act.cnt), 256'(exp.cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        in_t s, s2;
        #2;
        checkOutput("reset_valid", 256'(valid_out), 256'(0));
        checkOutput("reset_count", 256'(squash_count), 256'(0));
        checkOutput("reset_pc", 256'(pc_out), 256'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        s = '0;
        s.wb = 1'b1;
        s.cmd = 4'b0010;
        s.rn = 32'h0000_0005;
        s.dest = 4'd3;
        applyStimulus(s, 1'b0, 1'b0);
        checkOutput("load_wb", 256'(WB_en_out), 256'(1));
        checkOutput("load_cmd", 256'(exec_cmd_out), 256'(4'b0010));
        checkOutput("load_rn", 256'(val_rn_out), 256'(5));
        checkOutput("load_dest", 256'(dest_out), 256'(3));
        checkOutput("load_valid", 256'(valid_out), 256'(1));

        s2 = randStim(1'b1);
        s2.rn = 32'hA5A5_0001;
        s2.dest = 4'd9;
        repeat (3) applyStimulus(s2, 1'b1, 1'b0);
        checkOutput("freeze_rn", 256'(val_rn_out), 256'(5));
        checkOutput("freeze_dest", 256'(dest_out), 256'(3));
        applyStimulus(s2, 1'b0, 1'b0);
        checkOutput("unfreeze_rn", 256'(val_rn_out), 256'(32'hA5A5_0001));
        checkOutput("unfreeze_dest", 256'(dest_out), 256'(9));

        s = s2;
        s.mem_r = 1'b0;
        s.mem_w = 1'b1;
        applyStimulus(s, 1'b0, 1'b1);
        checkOutput("flush_memw", 256'(MEM_w_en_out), 256'(0));
        checkOutput("flush_valid", 256'(valid_out), 256'(0));
        checkOutput("flush_count", 256'(squash_count), 256'(1));

        applyStimulus(s2, 1'b0, 1'b0);
        repeat (2) applyStimulus(s2, 1'b1, 1'b1);
        checkOutput("frzflush_valid", 256'(valid_out), 256'(1));
        checkOutput("frzflush_count", 256'(squash_count), 256'(1));
        applyStimulus(s2, 1'b0, 1'b1);
        checkOutput("flushrel_valid", 256'(valid_out), 256'(0));
        checkOutput("flushrel_count", 256'(squash_count), 256'(2));

        repeat (300) begin
            applyStimulus(randStim(1'b0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
        end

        repeat (300) applyStimulus(randStim(1'b0), 1'b0, 1'b1);
        checkOutput("sat_count", 256'(squash_count), 256'(255));
        s = randStim(1'b1);
        s.mem_r = 1'b1;
        s.mem_w = 1'b1;
        applyStimulus(s, 1'b0, 1'b0);
        checkOutput("illegal_valid", 256'(valid_out), 256'(0));
        checkOutput("illegal_memr", 256'(MEM_r_en_out), 256'(0));
        checkOutput("illegal_count", 256'(squash_count), 256'(255));

        s = randStim(1'b1);
        applyStimulus(s, 1'b0, 1'b0);
        checkOutput("pre_rst_valid", 256'(valid_out), 256'(1));
        rst = 1'b1;
        #2;
        checkOutput("async_valid", 256'(valid_out), 256'(0));
        checkOutput("async_count", 256'(squash_count), 256'(0));
        checkOutput("async_all", 256'({MEM_r_en_out, MEM_w_en_out, WB_en_out, s_out, b_out, exec_cmd_out,
                                       pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
                                       signed_imm_24_out, dest_out, src1_out, src2_out, carry_out}),
                    256'(0));
        #4;
        rst = 1'b0;
        s = randStim(1'b1);
        s.carry = 1'b1;
        applyStimulus(s, 1'b0, 1'b0);
        checkOutput("carry_load", 256'(carry_out), 256'(1));
        checkOutput("carry_valid", 256'(valid_out), 256'(1));

        repeat (2) applyStimulus(s, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
